key_sched_ctrl: RTL and testbench

KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

---
 rtl/key_sched_ctrl.sv | 112 +++++++++++
 tb/tb_key_sched_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: AES-128 key expansion producing one round key per step through a single shared SubWord
// Ports: clk; rst (async, active-high); start + key request an expansion;
//        busy, rk_valid, rk_round, rk and done report the round-key stream.
// Build option: KEY_SCHED_SBOX_REG_EN registers the SubWord output and adds a SUB state per round.
module key_sched_ctrl #(
  parameter int BYTE = 8,
  parameter int WORD = 32,
  parameter int SENTENCE = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SENTENCE-1:0] key,
  output logic                busy,
  output logic                rk_valid,
  output logic [3:0]          rk_round,
  output logic [SENTENCE-1:0] rk,
  output logic                done
);
`ifdef KEY_SCHED_SBOX_REG_EN
  typedef enum logic [1:0] {IDLE, ROUND, SUB} state_t;
`else
  typedef enum logic {IDLE, ROUND} state_t;
`endif
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  state_t state, state_n;
  logic load, step;
  logic [3:0] rcon_idx;
  logic [WORD-1:0] w0, w1, w2, w3, rot, sub_w, sub_src, t, n4, n5, n6, n7;
  assign {w0, w1, w2, w3} = rk;
  assign rot = {w3[WORD-BYTE-1:0], w3[WORD-1:WORD-BYTE]};
  for (genvar i = 0; i < WORD / BYTE; i++) begin : g_sbox
    assign sub_w[i*BYTE +: BYTE] = SBOX[{8'd255 - rot[i*BYTE +: BYTE], 3'b000} +: 8];
  end
  // rk_round holds the round just produced, so it indexes Rcon of the next round; clamped to stay in range
  assign rcon_idx = rk_round > 4'd9 ? 4'd9 : rk_round;
  assign t = sub_src ^ {RCON[rcon_idx], {(WORD-BYTE){1'b0}}};
  assign n4 = w0 ^ t;
  assign n5 = w1 ^ n4;
  assign n6 = w2 ^ n5;
  assign n7 = w3 ^ n6;
  assign busy = state != IDLE;
`ifdef KEY_SCHED_SBOX_REG_EN
  logic sub_load;
  logic [WORD-1:0] sub_q;
  assign sub_src = sub_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sub_q <= '0;
    else if (sub_load) sub_q <= sub_w;
`else
  assign sub_src = sub_w;
`endif
  always_comb begin
    state_n = state;
    load = 1'b0;
    step = 1'b0;
`ifdef KEY_SCHED_SBOX_REG_EN
    sub_load = 1'b0;
`endif
    case (state)
      IDLE: begin
        load = start;
        state_n = start ? ROUND : IDLE;
      end
`ifdef KEY_SCHED_SBOX_REG_EN
      ROUND: begin
        sub_load = rk_round != 4'd10;
        state_n = rk_round == 4'd10 ? IDLE : SUB;
      end
      SUB: begin
        step = 1'b1;
        state_n = ROUND;
      end
`else
      ROUND: begin
        step = rk_round != 4'd10;
        state_n = rk_round == 4'd10 ? IDLE : ROUND;
      end
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rk_valid <= 1'b0;
      done <= 1'b0;
      rk_round <= 4'd0;
      rk <= '0;
    end else begin
      state <= state_n;
      rk_valid <= load | step;
      done <= step & (rk_round == 4'd9);
      if (load) begin
        rk <= key;
        rk_round <= 4'd0;
      end else if (step) begin
        rk <= {n4, n5, n6, n7};
        rk_round <= rk_round + 4'd1;
      end
    end
endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb_key_sched_ctrl: randomized self-checking bench for key_sched_ctrl against a FIPS-197 key expansion model
module tb_key_sched_ctrl;
`ifdef KEY_SCHED_SBOX_REG_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [127:0] key = '0;
  logic busy, rk_valid, done;
  logic [3:0] rk_round;
  logic [127:0] rk;
  int n_cmp = 0, n_fail = 0;
  logic [7:0] sb [256];
  logic [127:0] rk_exp [11];
  logic [127:0] cap [11];

  key_sched_ctrl dut (.clk(clk), .rst(rst), .start(start), .key(key), .busy(busy),
                      .rk_valid(rk_valid), .rk_round(rk_round), .rk(rk), .done(done));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map
  function automatic void build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00, s;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[a] = s;
    end
  endfunction

  function automatic void expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk_exp[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Caller is at a negedge; start is raised now and the run is followed cycle by cycle.
  task automatic run_seq(input logic [127:0] k, input bit hold, input bit early);
    int last, pulses, r;
    bit exp_v;
    logic [127:0] knext;
    last = 10 * STEP + 1;
    pulses = 0;
    expand(k);
    for (int i = 0; i < 11; i++) cap[i] = '0;
    start = 1'b1;
    key = k;
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge clk);
      exp_v = (c <= last) && ((c - 1) % STEP == 0);
      r = (c - 1) / STEP > 10 ? 10 : (c - 1) / STEP;
      n_cmp++;
      if (rk_valid !== exp_v) begin n_fail++; $display("FAIL rk_valid c=%0d got %b exp %b", c, rk_valid, exp_v); end
      n_cmp++;
      if (done !== (c == last)) begin n_fail++; $display("FAIL done c=%0d got %b exp %b", c, done, c == last); end
      n_cmp++;
      if (busy !== (c <= last)) begin n_fail++; $display("FAIL busy c=%0d got %b exp %b", c, busy, c <= last); end
      n_cmp++;
      if (rk !== rk_exp[r]) begin n_fail++; $display("FAIL rk c=%0d got %h exp %h", c, rk, rk_exp[r]); end
      n_cmp++;
      if (rk_round !== 4'(r)) begin n_fail++; $display("FAIL rk_round c=%0d got %0d exp %0d", c, rk_round, r); end
      if (rk_valid === 1'b1) begin
        pulses++;
        cap[rk_round] = rk;
      end
      if (hold) key = rand128();
      else start = early && (c == last);
    end
    n_cmp++;
    if (pulses != 11) begin n_fail++; $display("FAIL pulse_count got %0d exp 11", pulses); end
    if (hold) begin
      knext = key;
      @(negedge clk);
      n_cmp++;
      if (rk_valid !== 1'b1 || rk_round !== 4'd0 || rk !== knext) begin
        n_fail++;
        $display("FAIL second_run got v=%b r=%0d rk=%h exp v=1 r=0 rk=%h", rk_valid, rk_round, rk, knext);
      end
      start = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end else if (early) begin
      @(negedge clk);
      n_cmp++;
      if (rk_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL done_cycle_start got v=%b busy=%b exp v=0 busy=0", rk_valid, busy);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, rk_valid, done, rk_round, rk} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got busy=%b v=%b done=%b r=%0d rk=%h exp all zero", busy, rk_valid, done, rk_round, rk);
    end
    start = 1'b1;
    key = rand128();
    @(negedge clk);
    n_cmp++;
    if ({busy, rk_valid, done, rk_round, rk} !== '0) begin
      n_fail++;
      $display("FAIL reset_with_start got busy=%b v=%b r=%0d rk=%h exp all zero", busy, rk_valid, rk_round, rk);
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rk_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_reset got v=%b busy=%b exp 0 0", rk_valid, busy);
    end
  endtask

  task automatic test_vectors();
    run_seq(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b0);
    n_cmp++;
    if (cap[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      n_fail++; $display("FAIL fips_round1 got %h exp a0fafe1788542cb123a339392a6c7605", cap[1]);
    end
    n_cmp++;
    if (cap[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_fail++; $display("FAIL fips_round10 got %h exp d014f9a8c9ee2589e13f0cc8b6630ca6", cap[10]);
    end
    run_seq(128'h0, 1'b0, 1'b0);
    n_cmp++;
    if (cap[1] !== 128'h62636363626363636263636362636363) begin
      n_fail++; $display("FAIL zero_round1 got %h exp 62636363626363636263636362636363", cap[1]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) run_seq(rand128(), 1'b0, 1'b0);
  endtask

  task automatic test_hold_start();
    run_seq(rand128(), 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    key = rand128();
    @(negedge clk);
    start = 1'b0;
    repeat (5 * STEP) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, rk_valid, done, rk_round, rk} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got busy=%b v=%b done=%b r=%0d rk=%h exp all zero", busy, rk_valid, done, rk_round, rk);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12 * STEP; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rk_valid !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL quiet_after_reset c=%0d got v=%b done=%b exp 0 0", c, rk_valid, done);
      end
    end
    run_seq(rand128(), 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_seq(rand128(), 1'b0, 1'b0);
    run_seq(rand128(), 1'b0, 1'b0);
    run_seq(rand128(), 1'b0, 1'b1);
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_vectors();
    test_random();
    test_hold_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
